dmem_pipe: RTL and testbench

Parametrised, handshaked data memory: the successor to the single-cycle word-only data RAM. Serves one load or store at a time through valid/ready request and response channels, with a configurable access latency. Supports byte, halfword and word accesses, little-endian byte lanes, sign/zero extension on loads, and error reporting for misaligned or out-of-range addresses. Sits between the MEM stage of the pipeline and on-chip storage; the stage stalls on `req_ready`/`rsp_valid`.

---
 rtl/dmem_pipe.sv | 192 +++++++++++++++++++
 tb/tb_dmem_pipe.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_pipe.sv
// Handshaked data memory: one load/store in flight, configurable access latency,
// byte/halfword/word accesses with little-endian lanes and alignment/range errors.
module dmem_pipe #(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(LATENCY) + 1;
    localparam logic [CW-1:0] CntInit = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StResp
    } state_e;

    state_e        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;

    logic          r_we;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [31:0]   r_addr;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic          r_err;

    logic [31:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_commit;
    logic          w_rsp_take;
    logic [1:0]    w_lane;
    logic [AW-1:0] w_idx;
    logic          w_oob;
    logic          w_misalign;
    logic          w_err;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_rep;
    logic [31:0]   w_word;
    logic [31:0]   w_shifted;
    logic [31:0]   w_load;

    always_comb begin
        o_req_ready = (r_state == StIdle) | ((r_state == StResp) & i_rsp_ready);
        o_rsp_valid = (r_state == StResp);
        o_rsp_rdata = r_rdata;
        o_rsp_err   = r_err;
    end

    assign w_accept   = i_req_valid & o_req_ready;
    assign w_commit   = (r_state == StBusy) && (r_cnt == '0);
    assign w_rsp_take = (r_state == StResp) && i_rsp_ready;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (i_req_valid) begin
                    w_state_next = StBusy;
                    w_cnt_next   = CntInit;
                end
            end
            StBusy: begin
                if (r_cnt == '0) begin
                    w_state_next = StResp;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            StResp: begin
                // A new request may ride the same edge as the response handshake.
                if (i_rsp_ready) begin
                    if (i_req_valid) begin
                        w_state_next = StBusy;
                        w_cnt_next   = CntInit;
                    end else begin
                        w_state_next = StIdle;
                    end
                end
            end
            default: begin
                w_state_next = StIdle;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Address decode and error classification on the latched request.
    always_comb begin
        w_lane     = r_addr[1:0];
        w_idx      = r_addr[AW+1:2];
        w_oob      = |r_addr[31:AW+2];
        w_misalign = ((r_size == 2'b01) && r_addr[0]) ||
                     ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));
        w_err      = w_oob || w_misalign || (r_size == 2'b11);
    end

    always_comb begin
        case (r_size)
            2'b00: begin
                w_be        = 4'b0001 << w_lane;
                w_wdata_rep = {4{r_wdata[7:0]}};
            end
            2'b01: begin
                w_be        = 4'b0011 << w_lane;
                w_wdata_rep = {2{r_wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata_rep = r_wdata;
            end
        endcase
    end

    always_comb begin
        w_word    = r_mem[w_idx];
        w_shifted = w_word >> {w_lane, 3'b000};
        case (r_size)
            2'b00: begin
                w_load = r_unsigned ? {24'b0, w_shifted[7:0]}
                                    : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            2'b01: begin
                w_load = r_unsigned ? {16'b0, w_shifted[15:0]}
                                    : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
                w_load = w_shifted;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we       <= i_req_we;
                r_size     <= i_req_size;
                r_unsigned <= i_req_unsigned;
                r_addr     <= i_req_addr;
                r_wdata    <= i_req_wdata;
            end
            if (w_commit) begin
                r_rdata <= (w_err || r_we) ? 32'd0 : w_load;
                r_err   <= w_err;
            end else if (w_rsp_take) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end
        end
    end

    // Storage is intentionally not reset; writes gate on the reset-cleared state.
    always_ff @(posedge i_clk) begin
        if (w_commit && r_we && !w_err) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_pipe.sv
// Bench for dmem_pipe: two instances (latency 1 and 3), randomized traffic against a
// byte-addressed reference memory, queue-based scoreboard checked by an independent monitor.
`timescale 1ns/1ps
module tb_dmem_pipe;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned NB    = DEPTH * 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_we;
    logic [1:0][1:0]  req_size;
    logic [1:0]       req_unsigned;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][31:0] rsp_rdata;
    logic [1:0]       rsp_err;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_pipe #(
            .DEPTH  (DEPTH),
            .LATENCY((g == 0) ? 1 : 3)
        ) u_dut (
            .i_clk         (clk),
            .i_rst_n       (rst_n),
            .i_req_valid   (req_valid[g]),
            .o_req_ready   (req_ready[g]),
            .i_req_we      (req_we[g]),
            .i_req_size    (req_size[g]),
            .i_req_unsigned(req_unsigned[g]),
            .i_req_addr    (req_addr[g]),
            .i_req_wdata   (req_wdata[g]),
            .o_rsp_valid   (rsp_valid[g]),
            .i_rsp_ready   (rsp_ready[g]),
            .o_rsp_rdata   (rsp_rdata[g]),
            .o_rsp_err     (rsp_err[g])
        );
    end

    typedef struct {
        int          d;
        int          acc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mm [2][NB];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    bit         hold = 1'b0;
    bit         rnd_ready = 1'b0;
    bit         mon_off = 1'b0;
    int         hs_edge [2];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Byte-addressed reference: errors first, then lane-by-lane store or load with extension.
    function automatic void model(input int d, input logic we, input logic [1:0] size,
                                  input logic uns, input logic [31:0] addr,
                                  input logic [31:0] wdata,
                                  output logic [31:0] rdata, output logic err);
        int          n;
        logic [31:0] v;
        n     = 1 << size;
        err   = (size == 2'd3) || ((addr & (n - 1)) != 0) || (addr >= NB);
        rdata = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) mm[d][int'(addr) + i] = wdata[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v[8*i +: 8] = mm[d][int'(addr) + i];
                if (!uns && n < 4 && v[8*n-1]) begin
                    for (int b = 8 * n; b < 32; b++) v[b] = 1'b1;
                end
                rdata = v;
            end
        end
    endfunction

    initial begin
        rsp_ready = '1;
        forever begin
            @(negedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                rsp_ready[d] = hold ? 1'b0 : (rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
            end
        end
    end

    // Monitor: samples just before each rising edge, once inputs for that edge are settled.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (!mon_off && rst_n) begin
                for (int d = 0; d < 2; d++) begin
                    automatic exp_t e;
                    automatic bit   act_front = 1'b0;
                    automatic bit   exp_valid;
                    automatic bit   exp_ready;
                    if (q.size() > 0 && q[0].d == d && q[0].acc <= cyc) begin
                        act_front = 1'b1;
                        e         = q[0];
                    end
                    exp_valid = act_front && (cyc >= e.acc + lat_of(d));
                    exp_ready = !act_front || (exp_valid && rsp_ready[d]);
                    check($sformatf("rsp_valid[%0d]", d), 32'(rsp_valid[d]), 32'(exp_valid));
                    check($sformatf("req_ready[%0d]", d), 32'(req_ready[d]), 32'(exp_ready));
                    if (exp_valid && rsp_valid[d]) begin
                        check($sformatf("rsp_rdata[%0d]", d), rsp_rdata[d], e.rdata);
                        check($sformatf("rsp_err[%0d]", d), 32'(rsp_err[d]), 32'(e.err));
                        if (rsp_ready[d]) begin
                            void'(q.pop_front());
                            hs_edge[d] = cyc + 1;
                        end
                    end
                end
            end
        end
    end

    task automatic issue(input int d, input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit track,
                         output int acc);
        exp_t e;
        int   waited;
        @(negedge clk);
        #1;
        req_valid[d]    = 1'b1;
        req_we[d]       = we;
        req_size[d]     = size;
        req_unsigned[d] = uns;
        req_addr[d]     = addr;
        req_wdata[d]    = wdata;
        waited          = 0;
        forever begin
            #1;
            if (req_ready[d]) break;
            waited++;
            if (waited > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL accept_timeout[%0d]: got no accept, expected accept within 200", d);
                req_valid[d] = 1'b0;
                acc = -1;
                return;
            end
            @(negedge clk);
            #1;
        end
        acc = cyc + 1;
        if (track) begin
            e.d   = d;
            e.acc = acc;
            model(d, we, size, uns, addr, wdata, e.rdata, e.err);
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        // Garbage on the request fields outside the accept cycle must be ignored.
        req_valid[d]    = 1'b0;
        req_we[d]       = 1'($urandom);
        req_size[d]     = 2'($urandom);
        req_unsigned[d] = 1'($urandom);
        req_addr[d]     = $urandom;
        req_wdata[d]    = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() > 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: got %0d responses outstanding, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic run_random(input int d, input int n);
        int          acc;
        int          r;
        logic [31:0] addr;
        logic [1:0]  size;
        for (int w = 0; w < 16; w++) issue(d, 1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 1'b1, acc);
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      addr = $urandom;
            else if (r == 1) addr = NB + $urandom_range(0, 63);
            else             addr = 32'($urandom_range(0, 63));
            size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            issue(d, ($urandom_range(0, 2) == 0), size, 1'($urandom), addr, $urandom, 1'b1, acc);
        end
        drain();
    endtask

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int acc2;
        int t;
        req_valid    = '0;
        req_we       = '0;
        req_size     = '0;
        req_unsigned = '0;
        req_addr     = '0;
        req_wdata    = '0;
        repeat (3) @(negedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            check("reset req_ready", 32'(req_ready[d]), 32'd1);
            check("reset rsp_valid", 32'(rsp_valid[d]), 32'd0);
            check("reset rsp_rdata", rsp_rdata[d], 32'd0);
            check("reset rsp_err", 32'(rsp_err[d]), 32'd0);
        end
        rst_n = 1'b1;

        // Latency 1: directed word, sub-word, extension and error cases.
        issue(0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b1, acc);
        issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, acc);
        issue(0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, 1'b1, acc);
        issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, acc);
        issue(0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 1'b1, acc);
        issue(0, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, acc);
        issue(0, 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 1'b1, acc);
        issue(0, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b1, acc);
        issue(0, 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 1'b1, acc);
        issue(0, 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 1'b1, acc);
        issue(0, 1'b0, 2'd2, 1'b0, 32'h13, 32'h0, 1'b1, acc);
        issue(0, 1'b1, 2'd1, 1'b0, 32'h21, 32'h5555, 1'b1, acc);
        issue(0, 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 1'b1, acc);
        issue(0, 1'b1, 2'd2, 1'b0, 32'h0, 32'h01020304, 1'b1, acc);
        issue(0, 1'b1, 2'd2, 1'b0, 32'h400, 32'hFFFFFFFF, 1'b1, acc);
        issue(0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, acc);
        drain();
        check("model word 0x10", {mm[0][19], mm[0][18], mm[0][17], mm[0][16]}, 32'h1234AAEF);

        rnd_ready = 1'b1;
        run_random(0, 300);
        run_random(1, 200);
        rnd_ready = 1'b0;

        // Latency 3 backpressure: response held, then released with a new request waiting.
        hold = 1'b1;
        issue(1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, acc);
        t = 0;
        while (!rsp_valid[1] && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        #3;
        check("bp rsp_valid held", 32'(rsp_valid[1]), 32'd1);
        check("bp req_ready low", 32'(req_ready[1]), 32'd0);
        fork
            issue(1, 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 1'b1, acc2);
            begin
                @(posedge clk);
                hold = 1'b0;
            end
        join
        check("bp same-cycle accept", 32'(acc2), 32'(hs_edge[1]));
        drain();

        // Reset one cycle into an uncommitted store: the store must not land.
        mon_off = 1'b1;
        issue(1, 1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, 1'b0, acc);
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst req_ready", 32'(req_ready[1]), 32'd1);
        check("midrst rsp_valid", 32'(rsp_valid[1]), 32'd0);
        check("midrst rsp_rdata", rsp_rdata[1], 32'd0);
        check("midrst rsp_err", 32'(rsp_err[1]), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        rst_n   = 1'b1;
        mon_off = 1'b0;
        issue(1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, acc);
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
